// File: rtl/mips_debug_ctrl.sv
// Run/step enable and interrupt-request front end for the mips pipeline.
// Synchronises and debounces the raw board buttons and mode switch.
module mips_debug_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             debug_en,
  input  logic             debug_step,
  input  logic             int_btn,
  input  logic             int_ack,
  output logic             cpu_en,
  output logic             interrupter,
  output logic             debug_mode,
  output logic [CNT_W-1:0] step_count
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam int BTN_STEP = 0;
  localparam int BTN_INT  = 1;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_STEP = 1'b1;

  logic                 en_s1_q, en_s1_d;
  logic                 en_s2_q, en_s2_d;
  logic [1:0]           btn_raw;
  logic [1:0]           btn_s1_q, btn_s1_d;
  logic [1:0]           btn_s2_q, btn_s2_d;
  logic [1:0]           filt_q, filt_d;
  logic [1:0]           filt_dly_q, filt_dly_d;
  logic [1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]           btn_rise;
  logic                 cpu_en_q, cpu_en_d;
  logic                 int_q, int_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [0:0]           state;

  assign btn_raw  = {int_btn, debug_step};
  assign btn_rise = filt_q & ~filt_dly_q;
  assign state    = en_s2_q ? ST_STEP : ST_RUN;

  // Synchronisers and per-button debounce filters.
  always_comb begin
    en_s1_d    = debug_en;
    en_s2_d    = en_s1_q;
    btn_s1_d   = btn_raw;
    btn_s2_d   = btn_s1_q;
    filt_d     = filt_q;
    filt_dly_d = filt_q;
    db_cnt_d   = db_cnt_q;
    for (int b = 0; b < 2; b++) begin
      if (btn_s2_q[b] != filt_q[b]) begin
        if (db_cnt_q[b] == DB_LAST) begin
          filt_d[b]   = btn_s2_q[b];
          db_cnt_d[b] = '0;
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + DB_W'(1);
        end
      end else begin
        db_cnt_d[b] = '0;
      end
    end
  end

  // Mode FSM: free-running enable in RUN, one pulse per debounced press in STEP.
  always_comb begin
    cpu_en_d = 1'b1;
    count_d  = count_q;
    case (state)
      ST_RUN: cpu_en_d = 1'b1;
      ST_STEP: begin
        cpu_en_d = btn_rise[BTN_STEP];
        if (btn_rise[BTN_STEP]) begin
          count_d = count_q + CNT_W'(1);
        end
      end
      default: cpu_en_d = 1'b1;
    endcase
  end

  // A new request beats a simultaneous acknowledge.
  always_comb begin
    int_d = btn_rise[BTN_INT] | (int_q & ~int_ack);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_s1_q    <= 1'b0;
      en_s2_q    <= 1'b0;
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
      filt_q     <= '0;
      filt_dly_q <= '0;
      db_cnt_q   <= '0;
      cpu_en_q   <= 1'b0;
      int_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      en_s1_q    <= en_s1_d;
      en_s2_q    <= en_s2_d;
      btn_s1_q   <= btn_s1_d;
      btn_s2_q   <= btn_s2_d;
      filt_q     <= filt_d;
      filt_dly_q <= filt_dly_d;
      db_cnt_q   <= db_cnt_d;
      cpu_en_q   <= cpu_en_d;
      int_q      <= int_d;
      count_q    <= count_d;
    end
  end

  assign cpu_en      = cpu_en_q;
  assign interrupter = int_q;
  assign debug_mode  = en_s2_q;
  assign step_count  = count_q;

endmodule

// File: doc/mips_debug_ctrl.md
# mips_debug_ctrl

Front-end control block that sits directly upstream of the `mips` pipeline and drives its run-enable and interrupt-request inputs. It synchronises and debounces the raw board step button and interrupt button, and produces either a free-running enable or exactly one single-cycle enable pulse per step-button press. It also holds a level interrupt request until the CPU acknowledges it.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronised cycles a button must hold its new level before the filtered level changes. Valid range is ≥2. Boards use a larger value.
- `CNT_W`, default 16: width of the step counter.

Ports:
- `clk` in 1: single system clock; all state is on its rising edge.
- `rst` in 1: asynchronous, active-high reset; clears all state immediately.
- `debug_en` in 1: raw switch. 1 = single-step mode, 0 = free run.
- `debug_step` in 1: raw, bouncy step push-button.
- `int_btn` in 1: raw, bouncy interrupt push-button.
- `int_ack` in 1: synchronous level from the CPU; clears the pending interrupt.
- `cpu_en` out 1: pipeline advance enable, registered.
- `interrupter` out 1: pending interrupt request to the CPU, registered.
- `debug_mode` out 1: synchronised `debug_en`.
- `step_count` out `CNT_W`: number of step pulses issued since reset.

## Operation
- **Synchronisers.** `debug_en`, `debug_step` and `int_btn` each pass through a 2-flop synchroniser. The synchroniser flops reset to 0. `debug_mode` is the second flop of the `debug_en` synchroniser.
- **Debounce filter.** There is one filter per button, each with its own counter.
  - While the synchronised value differs from the filtered level, the counter increments.
  - When the counter reaches `DEBOUNCE_CYCLES-1` and the values still differ, the filtered level takes the synchronised value and the counter returns to 0.
  - Any cycle where the values match clears the counter to 0.
  - The filtered level resets to 0.
- **Edge detect.** A filter rising edge is detected by comparison with a 1-cycle delayed copy of the filtered level. Falling edges are ignored.
- **Mode FSM.** There are two states, decided by `debug_mode`.
  - RUN (`debug_mode`=0): `cpu_en` is registered to 1 every cycle. Step edges are ignored and not counted.
  - STEP (`debug_mode`=1): `cpu_en` is registered to 1 for exactly the one cycle following a step rising edge, and 0 otherwise. Each such pulse increments `step_count`.
  - RUN→STEP: `cpu_en` becomes 0 on the next edge. A step edge in the same cycle as the transition produces a pulse.
  - STEP→RUN: `cpu_en` becomes 1 on the next edge.
- **Held buttons.** A held step button yields one pulse only; there is no auto-repeat. A new pulse requires release, debounce low, then press and debounce high.
- **Step counter.** `step_count` is modulo 2^`CNT_W` and wraps from all-ones to 0 without a flag.
- **Interrupt.**
  - An `int_btn` rising edge sets `interrupter`. `int_ack`=1 clears it.
  - If set and clear occur in the same cycle, set wins and `interrupter` stays 1.
  - An edge arriving while `interrupter` is already 1 is absorbed; there is no queueing.
  - The interrupt path works identically in RUN and STEP modes.
- **Reset mid-operation.** Reset drops all outputs to 0 asynchronously and aborts any partial debounce. A button still held at reset release is treated as a fresh press: after the full debounce it generates a pulse, or sets `interrupter`.

## Timing
- **Reset values.** `cpu_en`=0, `interrupter`=0, `debug_mode`=0, `step_count`=0.
- **Start-up.** With `debug_en` held at 0, `cpu_en` rises at the first clock edge after `rst` deasserts.
- **Button latency.** Take a raw button stable high before edge 0.
  - The synchroniser output is high after edge 1.
  - The filtered level is high after edge `DEBOUNCE_CYCLES`+1.
  - In STEP mode, `cpu_en` is 1 for exactly the cycle between edges `DEBOUNCE_CYCLES`+2 and `DEBOUNCE_CYCLES`+3, and `step_count` increments at edge `DEBOUNCE_CYCLES`+2.
  - `interrupter` rises at edge `DEBOUNCE_CYCLES`+2.
- **Mode latency.** A `debug_en` change is visible on `debug_mode` after 2 edges; `cpu_en` follows one edge later.
- **Glitch rejection.** A raw pulse shorter than `DEBOUNCE_CYCLES` synchronised cycles never changes the filtered level.
- **Acknowledge latency.** `int_ack` sampled high at edge k clears `interrupter` after edge k.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- **Reset and free run.** Hold `rst` for 2 cycles with `debug_en`=0 → all outputs are 0 during reset; `cpu_en`=1 from the first edge after release and stays 1; `step_count`=0.
- **Single step.** Set `debug_en`=1 and wait 4 cycles, then hold `debug_step` high for 20 cycles → exactly one `cpu_en` high cycle, beginning after the 6th edge; `step_count`=1. Release, wait 10 cycles, press again → `step_count`=2.
- **Bounce rejection.** In STEP mode, toggle `debug_step` as 1,0,1,0 (1 cycle each), then 3 cycles high, then low → no `cpu_en` pulse; `step_count` unchanged.
- **Interrupt set/ack collision.** Press `int_btn` → `interrupter`=1 after the 6th edge. Pulse `int_ack` for 1 cycle → `interrupter`=0. Press again, timing `int_ack` to land on the same edge as the set → `interrupter` stays 1.
- **Mode switch with counter wrap.** Use `CNT_W`=2 and perform 4 steps → `step_count` reads 1,2,3,0. Drop `debug_en` → `cpu_en`=1 three edges later; presses in RUN mode do not change `step_count`.
- **Reset mid-debounce.** Hold `debug_step` high and assert `rst` after 3 cycles; release `rst` while the button is still held → no pulse before reset; exactly one pulse occurs 6 edges after reset release.
